// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte/half/word CPU access at any byte address into
// one or two aligned, byte-enabled word beats and returns one extended response.
module load_store_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            ls_type,
  input  logic                  load_unsigned,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int CNT_WIDTH = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  state_t                  state_r;
  logic [1:0]              off_r;
  logic [1:0]              size_r;
  logic                    write_r;
  logic                    uns_r;
  logic [3:0]              be_hi_r;
  logic [DATA_WIDTH-1:0]   wdata_hi_r;
  logic [DATA_WIDTH-1:0]   lo_word_r;
  logic [CNT_WIDTH-1:0]    cnt_r;

  logic [7:0]              be_wide_s;
  logic [2*DATA_WIDTH-1:0] wdata_wide_s;
  logic [2*DATA_WIDTH-1:0] raw_wide_s;
  logic [DATA_WIDTH-1:0]   raw_s;
  logic [DATA_WIDTH-1:0]   load_s;
  logic                    timeout_hit_s;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] raw,
                                                   input logic [1:0] size,
                                                   input logic uns);
    case (size)
      2'd0:    extend = uns ? {24'h000000, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    extend = uns ? {16'h0000, raw[15:0]}   : {{16{raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  // Lane placement over a two-word window: low half is beat 1, high half is beat 2.
  always_comb begin
    be_wide_s    = {4'b0000, size_mask(ls_type)} << addr[1:0];
    wdata_wide_s = {{DATA_WIDTH{1'b0}}, wdata} << {addr[1:0], 3'b000};
  end

  // Load assembly from the beat-1 word (if any) and the word acked this cycle.
  always_comb begin
    if (state_r == BEAT2) begin
      raw_wide_s = {mem_rdata, lo_word_r};
    end else begin
      raw_wide_s = {{DATA_WIDTH{1'b0}}, mem_rdata};
    end
    raw_s = DATA_WIDTH'(raw_wide_s >> {off_r, 3'b000});
    if (write_r) begin
      load_s = {DATA_WIDTH{1'b0}};
    end else begin
      load_s = extend(raw_s, size_r, uns_r);
    end
  end

  // Beat abort condition; a zero limit never fires.
  always_comb begin
    if (ACK_TIMEOUT == 0) begin
      timeout_hit_s = 1'b0;
    end else begin
      timeout_hit_s = (cnt_r == CNT_WIDTH'(ACK_TIMEOUT - 1));
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata      <= {DATA_WIDTH{1'b0}};
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_WIDTH{1'b0}};
      mem_be     <= 4'b0000;
      mem_wdata  <= {DATA_WIDTH{1'b0}};
      off_r      <= 2'd0;
      size_r     <= 2'd0;
      write_r    <= 1'b0;
      uns_r      <= 1'b0;
      be_hi_r    <= 4'b0000;
      wdata_hi_r <= {DATA_WIDTH{1'b0}};
      lo_word_r  <= {DATA_WIDTH{1'b0}};
      cnt_r      <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            off_r      <= addr[1:0];
            size_r     <= ls_type;
            write_r    <= req_write;
            uns_r      <= load_unsigned;
            be_hi_r    <= be_wide_s[7:4];
            wdata_hi_r <= wdata_wide_s[2*DATA_WIDTH-1:DATA_WIDTH];
            cnt_r      <= {CNT_WIDTH{1'b0}};
            if (ls_type == 2'd3) begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              rdata      <= {DATA_WIDTH{1'b0}};
            end else begin
              state_r   <= BEAT1;
              mem_req   <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              mem_be    <= be_wide_s[3:0];
              mem_wdata <= wdata_wide_s[DATA_WIDTH-1:0];
            end
          end
        end
        BEAT1, BEAT2: begin
          if (mem_ack && (state_r == BEAT1) && (be_hi_r != 4'b0000)) begin
            state_r   <= BEAT2;
            cnt_r     <= {CNT_WIDTH{1'b0}};
            lo_word_r <= mem_rdata;
            mem_addr  <= mem_addr + ADDR_WIDTH'(32'd4);
            mem_be    <= be_hi_r;
            mem_wdata <= wdata_hi_r;
          end else if (mem_ack || timeout_hit_s) begin
            // A timed-out split store keeps whatever beat 1 already wrote.
            state_r    <= RESP;
            cnt_r      <= {CNT_WIDTH{1'b0}};
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_wdata  <= {DATA_WIDTH{1'b0}};
            resp_valid <= 1'b1;
            resp_err   <= ~mem_ack;
            rdata      <= mem_ack ? load_s : {DATA_WIDTH{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
          end
        end
        RESP: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          rdata      <= {DATA_WIDTH{1'b0}};
        end
        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          mem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random accesses
// checked against a byte-addressed reference memory and a beat-list model.
module tb_load_store_unit;

  localparam int ACK_TIMEOUT = 16;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  ls_type;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_words [logic [31:0]];
  logic [7:0]  ref_mem   [logic [31:0]];
  beat_t       beat_log[$];
  int          ack_limit   = 1000;
  int          delay_fixed = -1;
  int          beats_acked = 0;
  int          delay_sum   = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .ls_type(ls_type), .load_unsigned(load_unsigned),
    .addr(addr), .wdata(wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fill_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] read_word(input logic [31:0] wa);
    if (mem_words.exists(wa)) return mem_words[wa];
    return fill_word(wa);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] ba);
    logic [31:0] w;
    if (ref_mem.exists(ba)) return ref_mem[ba];
    w = fill_word({ba[31:2], 2'b00});
    return w[8*ba[1:0] +: 8];
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] v);
    mem_words[wa] = v;
    for (int k = 0; k < 4; k++) ref_mem[wa + k] = v[8*k +: 8];
  endtask

  // Memory responder: configurable wait states, byte-enabled writes, beat logging.
  initial begin
    beat_t cap;
    int    wait_left;
    int    beat_delay;
    bit    in_beat;
    logic [31:0] w;
    in_beat = 1'b0;
    wait_left = 0;
    beat_delay = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        in_beat = 1'b0;
      end
      if (!mem_req) begin
        in_beat = 1'b0;
      end else begin
        if (!in_beat) begin
          in_beat = 1'b1;
          cap.addr = mem_addr; cap.be = mem_be; cap.we = mem_we; cap.wdata = mem_wdata;
          beat_log.push_back(cap);
          if (beats_acked >= ack_limit) wait_left = -1;
          else if (delay_fixed >= 0) wait_left = delay_fixed;
          else wait_left = $urandom_range(0, 3);
          beat_delay = wait_left;
        end else begin
          check_value("stable_ctl", {mem_we, mem_be, mem_addr}, {cap.we, cap.be, cap.addr});
          check_value("stable_wdata", mem_wdata, cap.wdata);
        end
        if (wait_left == 0) begin
          w = read_word(mem_addr);
          mem_rdata = w;
          if (mem_we) begin
            for (int k = 0; k < 4; k++) if (mem_be[k]) w[8*k +: 8] = mem_wdata[8*k +: 8];
            mem_words[mem_addr] = w;
          end
          mem_ack = 1'b1;
          beats_acked++;
          delay_sum += beat_delay;
        end else if (wait_left > 0) begin
          wait_left--;
        end
      end
    end
  end

  task automatic do_txn(input logic we, input logic [1:0] ty, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    beat_t exp_q[$];
    beat_t cur;
    bit    have_cur;
    int    n, lat, exp_lat, lane;
    logic [31:0] ba, wa, exp_rdata;
    logic [63:0] acc, mask;
    logic exp_err;
    n = (ty == 2'd0) ? 1 : (ty == 2'd1) ? 2 : 4;
    have_cur = 1'b0;
    acc = 64'h0;
    if (ty != 2'd3) begin
      for (int i = 0; i < n; i++) begin
        ba = a + i;
        wa = {ba[31:2], 2'b00};
        lane = ba[1:0];
        if (have_cur && cur.addr != wa) begin
          exp_q.push_back(cur);
          have_cur = 1'b0;
        end
        if (!have_cur) begin
          cur.addr = wa; cur.be = 4'b0000; cur.we = we; cur.wdata = 32'h0;
          have_cur = 1'b1;
        end
        cur.be[lane] = 1'b1;
        cur.wdata[8*lane +: 8] = wd[8*i +: 8];
        acc[8*i +: 8] = ref_byte(ba);
      end
      exp_q.push_back(cur);
    end
    exp_err = (ty == 2'd3) || (ack_limit == 0);
    if (ack_limit == 0) while (exp_q.size() > 1) exp_q.pop_back();
    mask = (64'd1 << (8 * n)) - 64'd1;
    if (!uns && acc[8*n-1]) acc = acc | ~mask;
    exp_rdata = (exp_err || we) ? 32'h0 : acc[31:0];

    @(posedge clk); #1;
    check_value("req_ready_idle", req_ready, 1'b1);
    beat_log.delete();
    beats_acked = 0;
    delay_sum = 0;
    req_valid = 1'b1; req_write = we; ls_type = ty; load_unsigned = uns; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    got = rdata;
    if (!resp_valid) begin
      check_value("resp_wait", 1'b0, 1'b1);
      return;
    end
    if (ty == 2'd3) exp_lat = 1;
    else if (ack_limit == 0) exp_lat = 1 + ACK_TIMEOUT;
    else exp_lat = 1 + exp_q.size() + delay_sum;
    check_value("latency", lat, exp_lat);
    check_value("resp_err", resp_err, exp_err);
    check_value("rdata", rdata, exp_rdata);
    check_value("mem_req_in_resp", mem_req, 1'b0);
    check_value("beat_count", beat_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < beat_log.size(); i++) begin
      check_value("beat_addr", beat_log[i].addr, exp_q[i].addr);
      check_value("beat_we_be", {beat_log[i].we, beat_log[i].be}, {exp_q[i].we, exp_q[i].be});
      if (we) check_value("beat_wdata", beat_log[i].wdata & be_mask(exp_q[i].be), exp_q[i].wdata);
    end
    @(posedge clk); #1;
    check_value("resp_one_cycle", resp_valid, 1'b0);
    check_value("ready_after_resp", req_ready, 1'b1);
    if (!exp_err && we) for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=0 exp=1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] ra;
    logic [1:0]  rt;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; ls_type = 2'd0;
    load_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_ready", req_ready, 1'b1);
    check_value("rst_outs", {mem_req, mem_we, mem_be, resp_valid, resp_err}, 9'h0);
    check_value("rst_addr_data", {mem_addr, mem_wdata}, 64'h0);
    check_value("rst_rdata", rdata, 32'h0);
    rst = 1'b0;

    delay_fixed = 0;
    do_txn(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, got);
    preload(32'h40, 32'h80FF1234);
    do_txn(1'b0, 2'd0, 1'b0, 32'h43, 32'h0, got);
    check_value("lb_signed", got, 32'hFFFFFF80);
    do_txn(1'b0, 2'd0, 1'b1, 32'h43, 32'h0, got);
    check_value("lbu", got, 32'h00000080);
    do_txn(1'b0, 2'd1, 1'b0, 32'h41, 32'h0, got);
    check_value("lh_41", got, 32'hFFFFFF12);
    preload(32'h40, 32'h11223344);
    preload(32'h44, 32'h55667788);
    do_txn(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, got);
    check_value("lw_split", got, 32'h77881122);
    do_txn(1'b1, 2'd1, 1'b0, 32'h47, 32'h0000ABCD, got);
    check_value("sh_split_mem44", mem_words[32'h44], 32'hCD667788);
    check_value("sh_split_mem48", read_word(32'h48) & 32'hFF, 32'hAB);
    delay_fixed = 3;
    do_txn(1'b1, 2'd2, 1'b0, 32'h80, 32'h01234567, got);
    delay_fixed = 0;
    ack_limit = 0;
    do_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, got);
    ack_limit = 1000;
    do_txn(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, got);
    preload(32'hFFFFFFFC, 32'hA1B2C3D4);
    preload(32'h00000000, 32'h0F1E2D3C);
    do_txn(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, got);
    check_value("lw_wrap", got, 32'h2D3CA1B2);

    // Reset while the second beat of a split load is outstanding.
    ack_limit = 1;
    @(posedge clk); #1;
    beats_acked = 0;
    req_valid = 1'b1; req_write = 1'b0; ls_type = 2'd2; addr = 32'h42;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_value("beat2_addr", {mem_req, mem_addr}, {1'b1, 32'h44});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_value("rst_beat2", {mem_req, req_ready, resp_valid}, 3'b010);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_value("no_resp_after_rst", resp_valid, 1'b0);
    end
    ack_limit = 1000;
    do_txn(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, got);
    check_value("post_rst_lw", got, 32'h77881122);

    delay_fixed = -1;
    for (int t = 0; t < 150; t++) begin
      rt = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 7)
                                       : 32'h100 + $urandom_range(0, 63);
      do_txn(1'($urandom_range(0, 1)), rt, 1'($urandom_range(0, 1)), ra, $urandom, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
